diff_amp_stim_dsm: RTL and testbench

//  Digital stimulus generator that drives the diff-amp inputs (vin+, vb) through external RC filters.
//  - Host writes 8-bit level codes over the dedicated/bidir pins.
//  - Two first-order sigma-delta modulators turn the codes into 1-bit streams on uo_out.
//  - An optional sweep engine ramps the vin+ code for transfer-curve tests.
//  - Sits beside the analog amp in the same tile; the amp's ua[] pins are fed off-chip from uo_out.

---
 rtl/diff_amp_stim_pkg.sv | 30 +++
 rtl/diff_amp_stim_dsm_dsm1.sv | 44 ++++
 rtl/diff_amp_stim_dsm.sv | 178 +++++++++++++++++
 tb/tb_diff_amp_stim_dsm.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_amp_stim_pkg.sv
// -----------------------------------------------------------------------------
// diff_amp_stim_pkg
// Shared constants for the diff-amp stimulus generator: register map addresses,
// CTRL bit positions, uo_out bit positions and the sweep FSM state type.
// -----------------------------------------------------------------------------
package diff_amp_stim_pkg;

    // Register map, selected by ui_in[2:1] during a write
    localparam logic [1:0] ADDR_CODE_P = 2'd0;
    localparam logic [1:0] ADDR_CODE_B = 2'd1;
    localparam logic [1:0] ADDR_STEP   = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_SWEEP_EN = 0;
    localparam int CTRL_MODE     = 1;

    // uo_out bit positions
    localparam int UO_DSM_P     = 0;
    localparam int UO_DSM_B     = 1;
    localparam int UO_SWEEP_DIR = 2;
    localparam int UO_TURN      = 3;

    // Sweep direction FSM; UP doubles as the "dir=1" output level
    typedef enum logic {
        ST_DOWN = 1'b0,
        ST_UP   = 1'b1
    } sweepState_t;

endpackage

// File: rtl/diff_amp_stim_dsm_dsm1.sv
// -----------------------------------------------------------------------------
// dsm1
// First-order sigma-delta modulator. Each enabled clock adds the code into a
// WIDTH-bit accumulator; the carry out becomes the 1-bit output, so the long
// term ones density is code / 2**WIDTH.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   en       in   advance the accumulator (holds state when low)
//   code     in   WIDTH-bit level code
//   bit_out  out  registered carry, the modulated bit stream
// -----------------------------------------------------------------------------
module dsm1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] code,
    output logic             bit_out
);

    logic [WIDTH-1:0] r_acc;
    logic             r_bit;
    logic [WIDTH:0]   w_sum;

    // One extra bit on the adder holds the carry that drives the output
    assign w_sum = {1'b0, r_acc} + {1'b0, code};

    // Accumulate and capture the carry together; both freeze while en is low
    // so the stream resumes exactly where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_bit <= 1'b0;
        end else if (en) begin
            r_acc <= w_sum[WIDTH-1:0];
            r_bit <= w_sum[WIDTH];
        end
    end

    assign bit_out = r_bit;

endmodule

// File: rtl/diff_amp_stim_dsm.sv
// -----------------------------------------------------------------------------
// diff_amp_stim_dsm
// Digital stimulus generator for the diff-amp tile. The host writes 8-bit level
// codes through an asynchronous strobe; two sigma-delta modulators turn the
// vin+ and vb codes into 1-bit streams that are RC-filtered off chip. A sweep
// engine can ramp the vin+ code as a triangle or sawtooth.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   0 freezes modulators and prescaler; writes still accepted
//   ui_in    in   [0] write strobe (async), [2:1] register address
//   uio_in   in   write data byte
//   uo_out   out  [0] dsm_p, [1] dsm_b, [2] sweep_dir, [3] turn pulse
//   uio_out  out  tied 0
//   uio_oe   out  tied 0, bidir pins are inputs
// -----------------------------------------------------------------------------
module diff_amp_stim_dsm
    import diff_amp_stim_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SWEEP_DIV   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int                   PRESC_W  = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;
    localparam logic [PRESC_W-1:0]   PRESC_TC = PRESC_W'(SWEEP_DIV - 1);
    localparam logic [WIDTH-1:0]     CODE_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_syncPrev;
    logic                   w_wrPulse;
    logic [1:0]             w_addr;
    logic [WIDTH-1:0]       w_data;
    logic                   w_wrCodeP;

    logic [WIDTH-1:0]       r_codeP;
    logic [WIDTH-1:0]       r_codeB;
    logic [WIDTH-1:0]       r_step;
    logic [1:0]             r_ctrl;
    sweepState_t            r_state;
    logic                   r_turn;

    logic [PRESC_W-1:0]     r_presc;
    logic                   w_tick;
    logic [WIDTH:0]         w_sumUp;

    logic                   w_dsmP;
    logic                   w_dsmB;
    logic                   w_unused;

    // Bring the asynchronous strobe into the clock domain. r_syncPrev remembers
    // the last synchronized level so only the rising edge produces a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_syncPrev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], ui_in[0]};
            r_syncPrev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Address and data come straight from the pins; the host keeps them stable
    // across the synchronizer delay, so they are valid when the pulse fires.
    assign w_wrPulse = r_sync[SYNC_STAGES-1] & ~r_syncPrev;
    assign w_addr    = ui_in[2:1];
    assign w_data    = WIDTH'(uio_in);
    assign w_wrCodeP = w_wrPulse && (w_addr == ADDR_CODE_P);

    // Prescaler: wraps every SWEEP_DIV enabled cycles. It is held at zero while
    // the sweep is off so the first step after enabling is a full period away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (!r_ctrl[CTRL_SWEEP_EN]) begin
            r_presc <= '0;
        end else if (ena) begin
            r_presc <= (r_presc == PRESC_TC) ? '0 : r_presc + PRESC_W'(1);
        end
    end

    assign w_tick  = ena && r_ctrl[CTRL_SWEEP_EN] && (r_presc == PRESC_TC);
    assign w_sumUp = {1'b0, r_codeP} + {1'b0, r_step};

    // Register file and sweep FSM share one block because both write CODE_P.
    // A host write to CODE_P on a tick cycle wins outright: the step is skipped
    // and the direction state is left alone. Writes to the other registers do
    // not block the tick, which then uses the pre-write STEP/CTRL values.
    // Sawtooth ticks always leave the FSM in UP, so switching mode mid-sweep
    // forces the direction up on the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_codeP <= '0;
            r_codeB <= '0;
            r_step  <= '0;
            r_ctrl  <= '0;
            r_state <= ST_UP;
            r_turn  <= 1'b0;
        end else begin
            r_turn <= 1'b0;
            if (w_wrPulse) begin
                case (w_addr)
                    ADDR_CODE_P: r_codeP <= w_data;
                    ADDR_CODE_B: r_codeB <= w_data;
                    ADDR_STEP:   r_step  <= w_data;
                    ADDR_CTRL:   r_ctrl  <= w_data[1:0];
                endcase
            end
            if (w_tick && !w_wrCodeP) begin
                if (r_ctrl[CTRL_MODE]) begin
                    r_codeP <= w_sumUp[WIDTH-1:0];
                    r_turn  <= w_sumUp[WIDTH];
                    r_state <= ST_UP;
                end else begin
                    case (r_state)
                        ST_UP: begin
                            if (w_sumUp[WIDTH]) begin
                                r_codeP <= CODE_MAX;
                                r_state <= ST_DOWN;
                                r_turn  <= 1'b1;
                            end else begin
                                r_codeP <= w_sumUp[WIDTH-1:0];
                            end
                        end
                        ST_DOWN: begin
                            if (r_codeP < r_step) begin
                                r_codeP <= '0;
                                r_state <= ST_UP;
                                r_turn  <= 1'b1;
                            end else begin
                                r_codeP <= r_codeP - r_step;
                            end
                        end
                    endcase
                end
            end
        end
    end

    dsm1 #(.WIDTH(WIDTH)) u_dsmP (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ena),
        .code    (r_codeP),
        .bit_out (w_dsmP)
    );

    dsm1 #(.WIDTH(WIDTH)) u_dsmB (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (ena),
        .code    (r_codeB),
        .bit_out (w_dsmB)
    );

    // Output byte assembled from registered sources only
    always_comb begin
        uo_out               = '0;
        uo_out[UO_DSM_P]     = w_dsmP;
        uo_out[UO_DSM_B]     = w_dsmB;
        uo_out[UO_SWEEP_DIR] = (r_state == ST_UP);
        uo_out[UO_TURN]      = r_turn;
    end

    assign uio_out  = '0;
    assign uio_oe   = '0;
    assign w_unused = &{1'b0, ui_in[7:3]};

endmodule

// File: tb/tb_diff_amp_stim_dsm.sv
// -----------------------------------------------------------------------------
// tb_diff_amp_stim_dsm
// Self-checking bench for diff_amp_stim_dsm. A behavioural model of the
// register map, sweep rules and modulator ones density predicts every value.
// -----------------------------------------------------------------------------
module tb_diff_amp_stim_dsm;
    import diff_amp_stim_pkg::*;

    localparam int SWEEP_DIV = 16;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       ena    = 1'b0;
    logic [7:0] ui_in  = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model state
    int mCode, mCodeB, mStep, mDir, mMode, mSweep, mTurn;

    diff_amp_stim_dsm #(
        .WIDTH       (8),
        .SYNC_STAGES (2),
        .SWEEP_DIV   (SWEEP_DIV)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input int expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] probeReg(input int addr);
        logic [31:0] v;
        case (addr)
            0:       v = 32'(dut.r_codeP);
            1:       v = 32'(dut.r_codeB);
            2:       v = 32'(dut.r_step);
            default: v = 32'(dut.r_ctrl);
        endcase
        return v;
    endfunction

    function automatic int modelReg(input int addr);
        int v;
        case (addr)
            0:       v = mCode;
            1:       v = mCodeB;
            2:       v = mStep;
            default: v = mMode * 2 + mSweep;
        endcase
        return v;
    endfunction

    // Sweep rules in plain integer arithmetic
    function automatic void modelTick();
        mTurn = 0;
        if (mMode == 1) begin
            mTurn = (mCode + mStep > 255) ? 1 : 0;
            mCode = (mCode + mStep) % 256;
            mDir  = 1;
        end else if (mDir == 1) begin
            if (mCode + mStep > 255) begin
                mCode = 255; mDir = 0; mTurn = 1;
            end else begin
                mCode = mCode + mStep;
            end
        end else begin
            if (mCode < mStep) begin
                mCode = 0; mDir = 1; mTurn = 1;
            end else begin
                mCode = mCode - mStep;
            end
        end
    endfunction

    task automatic resetDut();
        rst_n  = 1'b0;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("reset_uo_out", uo_out, 'h04);
        checkOutput("reset_uio_oe", uio_oe, 0);
        checkOutput("reset_uio_out", uio_out, 0);
        checkOutput("reset_code_p", probeReg(0), 0);
        rst_n  = 1'b1;
        mCode = 0; mCodeB = 0; mStep = 0; mDir = 1; mMode = 0; mSweep = 0; mTurn = 0;
    endtask

    // Host write: data set up 3 cycles ahead, strobe raised on a negedge,
    // register expected to change on the third rising edge after the strobe.
    task automatic applyStimulus(input int addr, input int data, input int holdCycles);
        ui_in[2:1] = addr[1:0];
        uio_in     = data[7:0];
        repeat (3) @(negedge clk);
        ui_in[0] = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("wr_before_latency", probeReg(addr), modelReg(addr));
        @(negedge clk);
        case (addr)
            0:       mCode  = data;
            1:       mCodeB = data;
            2:       mStep  = data;
            default: begin mSweep = data & 1; mMode = (data >> 1) & 1; end
        endcase
        checkOutput("wr_after_latency", probeReg(addr), modelReg(addr));
        if (holdCycles > 0) begin
            uio_in = ~data[7:0];
            repeat (holdCycles) @(negedge clk);
            checkOutput("wr_single_on_hold", probeReg(addr), modelReg(addr));
        end
        ui_in[0] = 1'b0;
    endtask

    task automatic countOnes(input int cycles, output int onesP, output int onesB);
        onesP = 0;
        onesB = 0;
        repeat (cycles) begin
            @(negedge clk);
            onesP += int'(uo_out[UO_DSM_P]);
            onesB += int'(uo_out[UO_DSM_B]);
        end
    endtask

    // elapsed = negedges already passed since the last sweep reference point
    task automatic sweepTick(input int elapsed);
        int waitLeft;
        waitLeft = SWEEP_DIV - 1 - elapsed;
        if (elapsed == 0) begin
            @(negedge clk);
            waitLeft--;
            checkOutput("turn_one_cycle", uo_out[UO_TURN], 0);
        end
        repeat (waitLeft) @(negedge clk);
        checkOutput("code_before_tick", probeReg(0), mCode);
        checkOutput("turn_before_tick", uo_out[UO_TURN], 0);
        @(negedge clk);
        modelTick();
        checkOutput("code_at_tick", probeReg(0), mCode);
        checkOutput("dir_at_tick", uo_out[UO_SWEEP_DIR], mDir);
        checkOutput("turn_at_tick", uo_out[UO_TURN], mTurn);
    endtask

    initial begin
        int onesP, onesB, c, cB, expBit;
        int triExp[8];
        triExp = '{'h50, 'hA0, 'hF0, 'hFF, 'hAF, 'h5F, 'h0F, 'h00};

        ena = 1'b1;
        resetDut();

        // Density of a fixed code over a full 256-cycle window
        applyStimulus(ADDR_CODE_P, 'h40, 0);
        @(negedge clk);
        countOnes(256, onesP, onesB);
        checkOutput("density_p_0x40", onesP, 'h40);

        for (int i = 0; i < 3; i++) begin
            cB = int'($urandom_range(0, 255));
            c  = int'($urandom_range(0, 255));
            applyStimulus(ADDR_CODE_B, cB, 0);
            applyStimulus(ADDR_CODE_P, c, 0);
            @(negedge clk);
            countOnes(256, onesP, onesB);
            checkOutput("density_p_rand", onesP, c);
            checkOutput("density_b_rand", onesB, cB);
        end

        // Extremes: all-but-one and never
        applyStimulus(ADDR_CODE_B, 'hFF, 0);
        applyStimulus(ADDR_CODE_P, 'h00, 0);
        @(negedge clk);
        countOnes(256, onesP, onesB);
        checkOutput("density_p_zero", onesP, 0);
        checkOutput("density_b_max", onesB, 255);

        // A strobe held high for 40 cycles must write only once
        applyStimulus(ADDR_CODE_P, 'h5A, 40);

        // A write cut short by reset leaves no trace
        ui_in[2:1] = 2'd0;
        uio_in     = 8'h77;
        @(negedge clk);
        ui_in[0] = 1'b1;
        @(negedge clk);
        rst_n    = 1'b0;
        ui_in[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mCode = 0; mCodeB = 0; mStep = 0; mDir = 1; mMode = 0; mSweep = 0; mTurn = 0;
        repeat (6) @(negedge clk);
        checkOutput("partial_write_lost", probeReg(0), 0);

        // Frozen modulator with ena low, then the exact bit sequence from acc=0
        for (int r = 0; r < 2; r++) begin
            resetDut();
            ena = 1'b0;
            c = (r == 0) ? 'h80 : int'($urandom_range(1, 255));
            applyStimulus(ADDR_CODE_P, c, 0);
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                checkOutput("ena_low_frozen", uo_out, 'h04);
            end
            ena = 1'b1;
            for (int k = 1; k <= 24; k++) begin
                @(negedge clk);
                expBit = ((k * c) / 256) - (((k - 1) * c) / 256);
                checkOutput("dsm_bit_sequence", uo_out[UO_DSM_P], expBit);
            end
        end

        // Triangle sweep, STEP=0x50 from 0
        resetDut();
        applyStimulus(ADDR_STEP, 'h50, 0);
        applyStimulus(ADDR_CTRL, 'h01, 0);
        for (int i = 0; i < 8; i++) begin
            sweepTick(0);
            checkOutput("triangle_code_list", probeReg(0), triExp[i]);
        end

        // ena low mid-period pauses the prescaler
        repeat (5) @(negedge clk);
        ena = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("ena_low_code_hold", probeReg(0), mCode);
        ena = 1'b1;
        sweepTick(5);

        // Host write to CODE_P lands on the tick edge: the write wins
        repeat (10) @(negedge clk);
        applyStimulus(ADDR_CODE_P, 'h11, 0);
        checkOutput("collision_dir_kept", uo_out[UO_SWEEP_DIR], mDir);
        sweepTick(0);
        checkOutput("collision_next_step", probeReg(0), 'h61);
        sweepTick(0);
        sweepTick(0);

        // Switch to sawtooth while heading down
        applyStimulus(ADDR_CTRL, 'h03, 0);
        sweepTick(6);
        checkOutput("saw_forces_dir_up", uo_out[UO_SWEEP_DIR], 1);

        // Clearing sweep_en keeps the last code
        applyStimulus(ADDR_CTRL, 'h00, 0);
        repeat (40) @(negedge clk);
        checkOutput("sweep_off_code_hold", probeReg(0), mCode);
        checkOutput("sweep_off_no_turn", uo_out[UO_TURN], 0);

        // Sawtooth STEP=0x60 from 0xC0 wraps to 0x20 with a turn pulse
        applyStimulus(ADDR_STEP, 'h60, 0);
        applyStimulus(ADDR_CODE_P, 'hC0, 0);
        applyStimulus(ADDR_CTRL, 'h03, 0);
        sweepTick(0);
        checkOutput("saw_wrap_code", probeReg(0), 'h20);
        checkOutput("saw_wrap_turn", uo_out[UO_TURN], 1);
        sweepTick(0);
        sweepTick(0);

        // Random triangle sweeps; each reset lands mid-sweep
        for (int r = 0; r < 3; r++) begin
            resetDut();
            c = (r == 0) ? 0 : int'($urandom_range(1, 255));
            applyStimulus(ADDR_STEP, c, 0);
            applyStimulus(ADDR_CODE_P, int'($urandom_range(0, 255)), 0);
            applyStimulus(ADDR_CTRL, 'h01, 0);
            for (int i = 0; i < 6; i++) sweepTick(0);
        end
        resetDut();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
